fft_engine: RTL and testbench

//  32-point radix-2 DIT complex FFT, 16-bit fixed point, with in-place sample RAM.
//  An upstream loader streams samples in two complex samples per cycle; on en the

---
 rtl/fft_engine.sv | 184 ++++++++++++++++++
 tb/tb_fft_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_engine.sv
`timescale 1ns/1ps
// 32-point radix-2 DIT complex FFT, Q1.15 data, Q1.14 twiddles, in-place sample RAM.
// Samples load bit-reversed; each butterfly halves its outputs, so the result is DFT/32.
module fft_engine #(
  parameter int WORDSIZE  = 16,
  parameter int ADDRSIZE  = 8,
  parameter int NUMSTAGES = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       ld_data,
  input  logic                       ld_done,
  input  logic signed [WORDSIZE-1:0] in0,
  input  logic signed [WORDSIZE-1:0] in1,
  input  logic signed [WORDSIZE-1:0] in2,
  input  logic signed [WORDSIZE-1:0] in3,
  output logic signed [WORDSIZE-1:0] out0,
  output logic signed [WORDSIZE-1:0] out1,
  output logic signed [WORDSIZE-1:0] out2,
  output logic signed [WORDSIZE-1:0] out3,
  output logic                       done
);

  localparam int W  = WORDSIZE;
  localparam int NB = 2**(NUMSTAGES-1);
  localparam int FB = W - 2;
  localparam logic signed [2*W-1:0] RND = (2*W)'(2**(FB-1));

  localparam logic signed [W-1:0] TW_RE [16] = '{
    16'sd16384, 16'sd16069, 16'sd15137, 16'sd13623, 16'sd11585, 16'sd9102, 16'sd6270, 16'sd3196,
    16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069};
  localparam logic signed [W-1:0] TW_IM [16] = '{
    16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
    -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623, -16'sd11585, -16'sd9102, -16'sd6270, -16'sd3196};

  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, OUT, DONE} state_t;

  state_t state_reg, state_next;
  logic [4:0] ld_cnt_reg, bfly_reg, out_cnt_reg;
  logic [2:0] stage_reg;
  logic       load_we, out_go, p1_valid, p2_valid;

  logic signed [W-1:0] mem_re [2**ADDRSIZE];
  logic signed [W-1:0] mem_im [2**ADDRSIZE];

  logic signed [W-1:0]   p1_a_re, p1_a_im, p1_b_re, p1_b_im, p1_w_re, p1_w_im;
  logic signed [W-1:0]   p2_a_re, p2_a_im;
  logic signed [W:0]     p2_t_re, p2_t_im;
  logic [ADDRSIZE-1:0]   p1_addr_a, p1_addr_b, p2_addr_a, p2_addr_b;
  logic signed [2*W-1:0] sum_re, sum_im;
  logic signed [W+1:0]   top_re, top_im, bot_re, bot_im;

  // Load addresses: sample index bit-reversed so the DIT output comes out in natural order
  logic [NUMSTAGES-1:0] ld_idx0, ld_idx1, ld_rev0, ld_rev1;
  assign ld_idx0 = {ld_cnt_reg[NUMSTAGES-2:0], 1'b0};
  assign ld_idx1 = {ld_cnt_reg[NUMSTAGES-2:0], 1'b1};
  generate
    for (genvar gi = 0; gi < NUMSTAGES; gi++) begin : g_bitrev
      assign ld_rev0[gi] = ld_idx0[NUMSTAGES-1-gi];
      assign ld_rev1[gi] = ld_idx1[NUMSTAGES-1-gi];
    end
  endgenerate

  // Butterfly c of stage s: group bits move up one place, span bit selects the B leg
  logic [NUMSTAGES-1:0] span, jmask, bfly_full, j_idx, bf_a, bf_b;
  logic [NUMSTAGES-2:0] tw_idx;
  assign span      = NUMSTAGES'(1) << stage_reg;
  assign jmask     = span - NUMSTAGES'(1);
  assign bfly_full = {1'b0, bfly_reg[NUMSTAGES-2:0]};
  assign j_idx     = bfly_full & jmask;
  assign bf_a      = ((bfly_full & ~jmask) << 1) | j_idx;
  assign bf_b      = bf_a | span;
  assign tw_idx    = (NUMSTAGES-1)'(j_idx << (3'(NUMSTAGES-1) - stage_reg));

  assign load_we = (state_reg == IDLE || state_reg == LOAD) && ld_data && !ld_done
                   && (ld_cnt_reg < 5'(NB));
  assign out_go  = (state_reg == OUT) && en && (out_cnt_reg < 5'(NB));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (ld_data) state_next = LOAD;
      LOAD:  if (ld_done) state_next = READY;
      READY: if (en) state_next = RUN;
      RUN: begin
        if (!en) state_next = IDLE;
        else if (stage_reg == 3'(NUMSTAGES-1) && bfly_reg == 5'(NB+2)) state_next = OUT;
      end
      OUT: begin
        if (!en) state_next = IDLE;
        else if (out_cnt_reg == 5'(NB)) state_next = DONE;
      end
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_reg  <= '0;
      bfly_reg    <= '0;
      stage_reg   <= '0;
      out_cnt_reg <= '0;
      p1_valid    <= 1'b0;
      p2_valid    <= 1'b0;
      done        <= 1'b0;
      out0 <= '0; out1 <= '0; out2 <= '0; out3 <= '0;
    end else begin
      if (state_next == IDLE) ld_cnt_reg <= '0;
      else if (load_we)       ld_cnt_reg <= ld_cnt_reg + 5'd1;

      // 16 issue slots plus 3 drain slots so a stage's writes land before the next reads
      if (state_reg == RUN && state_next == RUN) begin
        if (bfly_reg == 5'(NB+2)) begin
          bfly_reg  <= '0;
          stage_reg <= stage_reg + 3'd1;
        end else begin
          bfly_reg <= bfly_reg + 5'd1;
        end
      end else begin
        bfly_reg  <= '0;
        stage_reg <= '0;
      end

      p1_valid <= (state_reg == RUN) && en && (bfly_reg < 5'(NB));
      p2_valid <= p1_valid && (state_reg == RUN) && en;

      out_cnt_reg <= (state_reg == OUT && state_next == OUT) ? out_cnt_reg + 5'd1 : '0;
      done        <= (state_reg == OUT || state_reg == DONE) && en;

      if (out_go) begin
        out0 <= mem_re[ADDRSIZE'({out_cnt_reg[NUMSTAGES-2:0], 1'b0})];
        out1 <= mem_im[ADDRSIZE'({out_cnt_reg[NUMSTAGES-2:0], 1'b0})];
        out2 <= mem_re[ADDRSIZE'({out_cnt_reg[NUMSTAGES-2:0], 1'b1})];
        out3 <= mem_im[ADDRSIZE'({out_cnt_reg[NUMSTAGES-2:0], 1'b1})];
      end else begin
        out0 <= '0; out1 <= '0; out2 <= '0; out3 <= '0;
      end
    end
  end

  assign sum_re = p1_b_re * p1_w_re - p1_b_im * p1_w_im + RND;
  assign sum_im = p1_b_re * p1_w_im + p1_b_im * p1_w_re + RND;
  assign top_re = (W+2)'(p2_a_re) + (W+2)'(p2_t_re);
  assign top_im = (W+2)'(p2_a_im) + (W+2)'(p2_t_im);
  assign bot_re = (W+2)'(p2_a_re) - (W+2)'(p2_t_re);
  assign bot_im = (W+2)'(p2_a_im) - (W+2)'(p2_t_im);

  // Sample RAM plus read/multiply pipeline registers; none of this is reset
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re[ADDRSIZE'(ld_rev0)] <= in0;
      mem_im[ADDRSIZE'(ld_rev0)] <= in1;
      mem_re[ADDRSIZE'(ld_rev1)] <= in2;
      mem_im[ADDRSIZE'(ld_rev1)] <= in3;
    end else if (p2_valid) begin
      mem_re[p2_addr_a] <= W'(top_re >>> 1);
      mem_im[p2_addr_a] <= W'(top_im >>> 1);
      mem_re[p2_addr_b] <= W'(bot_re >>> 1);
      mem_im[p2_addr_b] <= W'(bot_im >>> 1);
    end
    p1_a_re   <= mem_re[ADDRSIZE'(bf_a)];
    p1_a_im   <= mem_im[ADDRSIZE'(bf_a)];
    p1_b_re   <= mem_re[ADDRSIZE'(bf_b)];
    p1_b_im   <= mem_im[ADDRSIZE'(bf_b)];
    p1_w_re   <= TW_RE[tw_idx];
    p1_w_im   <= TW_IM[tw_idx];
    p1_addr_a <= ADDRSIZE'(bf_a);
    p1_addr_b <= ADDRSIZE'(bf_b);
    p2_a_re   <= p1_a_re;
    p2_a_im   <= p1_a_im;
    p2_t_re   <= (W+1)'(sum_re >>> FB);
    p2_t_im   <= (W+1)'(sum_im >>> FB);
    p2_addr_a <= p1_addr_a;
    p2_addr_b <= p1_addr_b;
  end

endmodule

// File: tb/tb_fft_engine.sv
`timescale 1ns/1ps
// Directed bench for fft_engine: impulse, DC, tone, load handshake, abort, reset and re-run.
module tb_fft_engine;

  logic clk = 1'b0;
  logic rst, en, ld_data, ld_done;
  logic signed [15:0] in0, in1, in2, in3;
  logic signed [15:0] out0, out1, out2, out3;
  logic done;

  int checks = 0;
  int failures = 0;
  int xr[32], xi[32], rr[32], ri[32];
  int lat;

  always #5 clk = ~clk;

  fft_engine #(.WORDSIZE(16), .ADDRSIZE(8), .NUMSTAGES(5)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_data(ld_data), .ld_done(ld_done),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .done(done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_x();
    for (int n = 0; n < 32; n++) begin
      xr[n] = 0;
      xi[n] = 0;
    end
  endtask

  task automatic load_pairs(input int npairs);
    for (int k = 0; k < npairs; k++) begin
      ld_data = 1'b1; ld_done = 1'b0;
      in0 = 16'(xr[2*k]);   in1 = 16'(xi[2*k]);
      in2 = 16'(xr[2*k+1]); in3 = 16'(xi[2*k+1]);
      tick();
    end
    ld_data = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  // Raise en from READY, time done, capture the 32 bins, then close with en=0
  task automatic run_fft(input string tag);
    en = 1'b1;
    tick();
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 96);
    for (int k = 0; k < 16; k++) begin
      rr[2*k] = out0; ri[2*k] = out1; rr[2*k+1] = out2; ri[2*k+1] = out3;
      if (k < 15) tick();
    end
    tick();
    chk({tag, "_done_held"}, done, 1);
    chk({tag, "_out0_zero"}, out0, 0);
    chk({tag, "_out3_zero"}, out3, 0);
    en = 1'b0;
    tick();
    chk({tag, "_done_fall"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ld_data = 1'b0; ld_done = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_out0", out0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_out2", out2, 0);
    chk("rst_out3", out3, 0);
    rst = 1'b0;
    tick();

    // Impulse: every bin equals 3200/32
    clear_x();
    xr[0] = 3200;
    load_pairs(16);
    run_fft("imp");
    for (int n = 0; n < 32; n++) begin
      chk($sformatf("imp_re[%0d]", n), rr[n], 100);
      chk($sformatf("imp_im[%0d]", n), ri[n], 0);
    end

    // Handshake: 10 pairs of 100 over a RAM already holding (100,0) everywhere;
    // words offered after ld_done must not land
    for (int k = 0; k < 10; k++) begin
      ld_data = 1'b1; ld_done = 1'b0;
      in0 = 16'sd100; in1 = 16'sd0; in2 = 16'sd100; in3 = 16'sd0;
      tick();
    end
    ld_done = 1'b1; in0 = 16'sd5000; in1 = 16'sd5000; in2 = 16'sd5000; in3 = 16'sd5000;
    tick();
    ld_done = 1'b0;
    repeat (3) tick();
    ld_data = 1'b0;
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("hs_idle_done[%0d]", c), done, 0);
      tick();
    end
    run_fft("hs");
    chk("hs_re[0]", rr[0], 100);
    chk("hs_im[0]", ri[0], 0);
    for (int n = 1; n < 32; n++) begin
      chk($sformatf("hs_re[%0d]", n), rr[n], 0);
      chk($sformatf("hs_im[%0d]", n), ri[n], 0);
    end

    // DC: all energy in bin 0
    for (int n = 0; n < 32; n++) begin
      xr[n] = 320; xi[n] = 0;
    end
    load_pairs(16);
    run_fft("dc");
    chk_tol("dc_re[0]", rr[0], 320, 1);
    chk_tol("dc_im[0]", ri[0], 0, 1);
    for (int n = 1; n < 32; n++) begin
      chk_tol($sformatf("dc_re[%0d]", n), rr[n], 0, 1);
      chk_tol($sformatf("dc_im[%0d]", n), ri[n], 0, 1);
    end

    // Tone at bin 1
    for (int n = 0; n < 32; n++) begin
      real vr, vi;
      vr = 16000.0 * $cos(2.0 * 3.14159265358979 * n / 32.0);
      vi = 16000.0 * $sin(2.0 * 3.14159265358979 * n / 32.0);
      xr[n] = $rtoi(vr >= 0.0 ? vr + 0.5 : vr - 0.5);
      xi[n] = $rtoi(vi >= 0.0 ? vi + 0.5 : vi - 0.5);
    end
    load_pairs(16);
    run_fft("tone");
    chk_tol("tone_re[1]", rr[1], 16000, 2);
    chk_tol("tone_im[1]", ri[1], 0, 2);
    for (int n = 0; n < 32; n++) begin
      if (n != 1) chk_tol($sformatf("tone_mag2[%0d]", n), rr[n]*rr[n] + ri[n]*ri[n], 0, 4);
    end

    // Abort mid-RUN
    clear_x();
    xr[0] = 3200;
    load_pairs(16);
    en = 1'b1;
    repeat (40) tick();
    en = 1'b0;
    tick();
    chk("abort_done", done, 0);
    chk("abort_out0", out0, 0);
    repeat (5) tick();
    chk("abort_done_later", done, 0);

    // Asynchronous reset during OUT
    load_pairs(16);
    en = 1'b1;
    tick();
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("rst_run_latency", lat, 96);
    chk("rst_run_x0", out0, 100);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out0", out0, 0);
    chk("arst_out1", out1, 0);
    chk("arst_out2", out2, 0);
    chk("arst_out3", out3, 0);
    chk("arst_done", done, 0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Re-run with a new impulse
    clear_x();
    xr[0] = 6400;
    load_pairs(16);
    run_fft("rerun");
    for (int n = 0; n < 32; n++) begin
      chk($sformatf("rerun_re[%0d]", n), rr[n], 200);
      chk($sformatf("rerun_im[%0d]", n), ri[n], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
